// File: rtl/csr_file.sv
// csr_file: LoongArch CSR file with exception entry/return, interrupt status and timer.
// Optional stable-counter timer (TCFG/TVAL/TICLR) is built when CSR_TIMER_EN is defined.
module csr_file #(
    parameter logic [31:0] TID_INIT    = 32'h0,
    parameter logic [31:0] EENTRY_INIT = 32'h1c00_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        ertn_flush,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);

    localparam logic [13:0] CSR_CRMD   = 14'h00;
    localparam logic [13:0] CSR_PRMD   = 14'h01;
    localparam logic [13:0] CSR_ECFG   = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05;
    localparam logic [13:0] CSR_ERA    = 14'h06;
    localparam logic [13:0] CSR_EENTRY = 14'h0c;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [12:0] LIE_MASK   = 13'h1bff;

    logic [1:0]       plv_q, plv_d;
    logic             ie_q, ie_d;
    logic             da_q, da_d;
    logic [1:0]       pplv_q, pplv_d;
    logic             pie_q, pie_d;
    logic [12:0]      lie_q, lie_d;
    logic [12:0]      is_q, is_d;
    logic [5:0]       ecode_q, ecode_d;
    logic [8:0]       esub_q, esub_d;
    logic [31:0]      era_q, era_d;
    logic [25:0]      eentry_q, eentry_d;
    logic [3:0][31:0] save_q, save_d;
    logic [31:0]      tid_q, tid_d;
    logic [31:0]      rdata;

    logic [31:0] wm;
    logic [31:0] wv;
    logic        wr;
    logic        sel_crmd, sel_prmd, sel_ecfg, sel_estat;
    logic        sel_era, sel_eentry, sel_save, sel_tid;

    assign wm = csr_wmask;
    assign wv = csr_wvalue;
    assign wr = csr_we & ~wb_ex;

    assign sel_crmd   = (csr_num == CSR_CRMD);
    assign sel_prmd   = (csr_num == CSR_PRMD);
    assign sel_ecfg   = (csr_num == CSR_ECFG);
    assign sel_estat  = (csr_num == CSR_ESTAT);
    assign sel_era    = (csr_num == CSR_ERA);
    assign sel_eentry = (csr_num == CSR_EENTRY);
    assign sel_save   = (csr_num[13:2] == 12'h00c);
    assign sel_tid    = (csr_num == CSR_TID);

`ifdef CSR_TIMER_EN
    logic [31:0] tcfg_q, tcfg_d;
    logic [31:0] tval_q, tval_d;
    logic        sel_tcfg, sel_tval, sel_ticlr;
    logic        expire;

    assign sel_tcfg  = (csr_num == 14'h41);
    assign sel_tval  = (csr_num == 14'h42);
    assign sel_ticlr = (csr_num == 14'h44);
    assign expire    = tcfg_q[0] & (tval_q == 32'd0);
`endif

    // Next-state: masked writes, then exception/ertn overrides, IS sampling, timer
    always_comb begin
        plv_d    = plv_q;
        ie_d     = ie_q;
        da_d     = da_q;
        pplv_d   = pplv_q;
        pie_d    = pie_q;
        lie_d    = lie_q;
        is_d     = is_q;
        ecode_d  = ecode_q;
        esub_d   = esub_q;
        era_d    = era_q;
        eentry_d = eentry_q;
        save_d   = save_q;
        tid_d    = tid_q;
`ifdef CSR_TIMER_EN
        tcfg_d   = tcfg_q;
        tval_d   = tval_q;
`endif
        if (wr) begin
            unique case (1'b1)
                sel_crmd:
                    {da_d, ie_d, plv_d} = ({da_q, ie_q, plv_q} & ~wm[3:0])
                                        | (wv[3:0] & wm[3:0]);
                sel_prmd:
                    {pie_d, pplv_d} = ({pie_q, pplv_q} & ~wm[2:0])
                                    | (wv[2:0] & wm[2:0]);
                sel_ecfg:
                    lie_d = ((lie_q & ~wm[12:0]) | (wv[12:0] & wm[12:0]))
                          & LIE_MASK;
                sel_estat:
                    is_d[1:0] = (is_q[1:0] & ~wm[1:0]) | (wv[1:0] & wm[1:0]);
                sel_era:
                    era_d = (era_q & ~wm) | (wv & wm);
                sel_eentry:
                    eentry_d = (eentry_q & ~wm[31:6]) | (wv[31:6] & wm[31:6]);
                sel_save:
                    save_d[csr_num[1:0]] = (save_q[csr_num[1:0]] & ~wm)
                                         | (wv & wm);
                sel_tid:
                    tid_d = (tid_q & ~wm) | (wv & wm);
                default: ;
            endcase
        end
        if (wb_ex) begin
            pplv_d  = plv_q;
            pie_d   = ie_q;
            plv_d   = 2'b00;
            ie_d    = 1'b0;
            era_d   = wb_pc;
            ecode_d = wb_ecode;
            esub_d  = wb_esubcode;
        end else if (ertn_flush) begin
            plv_d = pplv_q;
            ie_d  = pie_q;
        end
        is_d[9:2] = hw_int_in;
        is_d[10]  = 1'b0;
        is_d[12]  = ipi_int_in;
`ifdef CSR_TIMER_EN
        if (wr && sel_ticlr && wv[0] && wm[0]) begin
            is_d[11] = 1'b0;
        end
        if (expire) begin
            is_d[11] = 1'b1;
            if (tcfg_q[1]) begin
                tval_d = {tcfg_q[31:2], 2'b00};
            end else begin
                tcfg_d[0] = 1'b0;
            end
        end else if (tcfg_q[0]) begin
            tval_d = tval_q - 32'd1;
        end
        if (wr && sel_tcfg) begin
            tcfg_d = (tcfg_q & ~wm) | (wv & wm);
            tval_d = tcfg_d[0] ? {tcfg_d[31:2], 2'b00} : tval_q;
        end
`else
        is_d[11] = 1'b0;
`endif
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            plv_q    <= 2'b00;
            ie_q     <= 1'b0;
            da_q     <= 1'b1;
            pplv_q   <= 2'b00;
            pie_q    <= 1'b0;
            lie_q    <= '0;
            is_q     <= '0;
            ecode_q  <= '0;
            esub_q   <= '0;
            era_q    <= '0;
            eentry_q <= EENTRY_INIT[31:6];
            save_q   <= '0;
            tid_q    <= TID_INIT;
`ifdef CSR_TIMER_EN
            tcfg_q   <= '0;
            tval_q   <= '0;
`endif
        end else begin
            plv_q    <= plv_d;
            ie_q     <= ie_d;
            da_q     <= da_d;
            pplv_q   <= pplv_d;
            pie_q    <= pie_d;
            lie_q    <= lie_d;
            is_q     <= is_d;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            eentry_q <= eentry_d;
            save_q   <= save_d;
            tid_q    <= tid_d;
`ifdef CSR_TIMER_EN
            tcfg_q   <= tcfg_d;
            tval_q   <= tval_d;
`endif
        end
    end

    // Read mux from current register values
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_crmd:   rdata = {28'b0, da_q, ie_q, plv_q};
            sel_prmd:   rdata = {29'b0, pie_q, pplv_q};
            sel_ecfg:   rdata = {19'b0, lie_q};
            sel_estat:  rdata = {1'b0, esub_q, ecode_q, 3'b0, is_q};
            sel_era:    rdata = era_q;
            sel_eentry: rdata = {eentry_q, 6'b0};
            sel_save:   rdata = save_q[csr_num[1:0]];
            sel_tid:    rdata = tid_q;
`ifdef CSR_TIMER_EN
            sel_tcfg:   rdata = tcfg_q;
            sel_tval:   rdata = tval_q;
            sel_ticlr:  rdata = '0;
`endif
            default:    rdata = '0;
        endcase
    end

    assign csr_rvalue = csr_re ? rdata : 32'd0;
    assign ex_entry   = {eentry_q, 6'b0};
    assign ertn_entry = era_q;
    assign has_int    = ie_q & (|(is_q & lie_q));

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed plus random stimulus for csr_file
// against a word-level CSR model.
module tb_csr_file;

`ifdef CSR_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif
    localparam logic [31:0] TIDI = 32'h0;
    localparam logic [31:0] EEI  = 32'h1c00_8000;

    logic        clk;
    logic        rst;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn_flush;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        has_int;

    int total = 0;
    int bad   = 0;
    logic [31:0] m [0:127];
    logic [31:0] last_rd;
    logic        last_int;

    csr_file #(.TID_INIT(TIDI), .EENTRY_INIT(EEI)) dut (
        .clk(clk), .rst(rst),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .ertn_flush(ertn_flush), .wb_ex(wb_ex),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .ex_entry(ex_entry), .ertn_entry(ertn_entry), .has_int(has_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wmask_of(input logic [13:0] n);
        case (n)
            14'h00: return 32'h0000_000f;
            14'h01: return 32'h0000_0007;
            14'h04: return 32'h0000_1bff;
            14'h05: return 32'h0000_0003;
            14'h06: return 32'hffff_ffff;
            14'h0c: return 32'hffff_ffc0;
            14'h30, 14'h31, 14'h32, 14'h33, 14'h40: return 32'hffff_ffff;
            14'h41: return TMR ? 32'hffff_ffff : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [13:0] n);
        case (n)
            14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h0c,
            14'h30, 14'h31, 14'h32, 14'h33, 14'h40,
            14'h41, 14'h42: return m[n[6:0]];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m[i] = 32'h0;
        m[0]  = 32'h8;
        m[12] = EEI;
        m[64] = TIDI;
    endtask

    task automatic model_step();
        logic [31:0] nx [0:127];
        logic [31:0] w;
        logic tw;
        logic ex_t;
        if (rst) begin
            model_reset();
            return;
        end
        nx = m;
        tw = 1'b0;
        if (csr_we && !wb_ex && csr_num < 14'd128) begin
            w = csr_wmask & wmask_of(csr_num);
            nx[csr_num[6:0]] = (m[csr_num[6:0]] & ~w) | (csr_wvalue & w);
            tw = TMR && (csr_num == 14'h41);
        end
        if (wb_ex) begin
            nx[1][2:0]   = m[0][2:0];
            nx[0][2:0]   = 3'b000;
            nx[6]        = wb_pc;
            nx[5][21:16] = wb_ecode;
            nx[5][30:22] = wb_esubcode;
        end else if (ertn_flush) begin
            nx[0][2:0] = m[1][2:0];
        end
        nx[5][9:2] = hw_int_in;
        nx[5][12]  = ipi_int_in;
        if (TMR) begin
            ex_t = m[65][0] && (m[66] == 32'h0);
            if (csr_we && !wb_ex && csr_num == 14'h44
                && csr_wvalue[0] && csr_wmask[0]) nx[5][11] = 1'b0;
            if (ex_t) nx[5][11] = 1'b1;
            if (tw) begin
                if (nx[65][0]) nx[66] = {nx[65][31:2], 2'b00};
            end else if (ex_t) begin
                if (m[65][1]) nx[66] = {m[65][31:2], 2'b00};
                else nx[65][0] = 1'b0;
            end else if (m[65][0]) begin
                nx[66] = m[66] - 32'd1;
            end
        end
        m = nx;
    endtask

    task automatic cyc(input logic re, input logic [13:0] num,
                       input logic we, input logic [31:0] wmk,
                       input logic [31:0] wvl, input logic ex,
                       input logic er);
        logic exp_int;
        csr_re = re; csr_num = num; csr_we = we;
        csr_wmask = wmk; csr_wvalue = wvl;
        wb_ex = ex; ertn_flush = er;
        #3;
        exp_int = m[0][2] & (|(m[5][12:0] & m[4][12:0]));
        last_rd  = csr_rvalue;
        last_int = has_int;
        chk("rvalue", csr_rvalue, re ? mread(num) : 32'h0);
        chk("ex_entry", ex_entry, m[12]);
        chk("ertn_entry", ertn_entry, m[6]);
        chk("has_int", {31'b0, has_int}, {31'b0, exp_int});
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rd(input logic [13:0] num);
        cyc(1'b1, num, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] v);
        cyc(1'b0, num, 1'b1, 32'hffff_ffff, v, 1'b0, 1'b0);
    endtask

    logic [13:0] nums [18];

    initial begin
        nums = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h0c,
                 14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41,
                 14'h42, 14'h44, 14'h7f, 14'h02, 14'h43, 14'h1000};
        rst = 1'b1; csr_re = 0; csr_num = 0; csr_we = 0;
        csr_wmask = 0; csr_wvalue = 0; ertn_flush = 0; wb_ex = 0;
        wb_ecode = 0; wb_esubcode = 0; wb_pc = 0;
        hw_int_in = 0; ipi_int_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        cyc(1'b0, 14'h00, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("rst_rvalue", last_rd, 32'h0);
        rd(14'h00);  chk("rst_crmd", last_rd, 32'h8);
        rd(14'h0c);  chk("rst_eentry", last_rd, 32'h1c00_8000);
        rd(14'h7f);  chk("unimpl", last_rd, 32'h0);

        cyc(1'b1, 14'h31, 1'b1, 32'hffff_0000, 32'hdead_beef, 1'b0, 1'b0);
        chk("save1_same", last_rd, 32'h0);
        rd(14'h31);  chk("save1", last_rd, 32'hdead_0000);

        wr(14'h00, 32'h7);
        wb_pc = 32'h1c00_0100; wb_ecode = 6'hb; wb_esubcode = 9'h0;
        cyc(1'b0, 14'h00, 1'b0, 0, 0, 1'b1, 1'b0);
        rd(14'h00);  chk("ex_crmd", last_rd, 32'h0);
        rd(14'h01);  chk("ex_prmd", last_rd, 32'h7);
        rd(14'h06);  chk("ex_era", last_rd, 32'h1c00_0100);
        rd(14'h05);  chk("ex_ecode", {26'b0, last_rd[21:16]}, 32'hb);
        cyc(1'b0, 14'h00, 1'b0, 0, 0, 1'b0, 1'b1);
        rd(14'h00);  chk("ertn_crmd", last_rd, 32'h7);

        cyc(1'b0, 14'h30, 1'b1, 32'hffff_ffff, 32'h5, 1'b1, 1'b0);
        rd(14'h30);  chk("ex_drop_we", last_rd, 32'h0);
        cyc(1'b0, 14'h00, 1'b0, 0, 0, 1'b1, 1'b1);
        rd(14'h00);  chk("ex_wins_crmd", last_rd, 32'h0);
        rd(14'h01);  chk("ex_wins_prmd", last_rd, 32'h0);

        wr(14'h04, 32'h1fff);
        rd(14'h04);  chk("lie_ro10", last_rd, 32'h1bff);
        wr(14'h04, 32'h800);
        wr(14'h00, 32'h4);
        wr(14'h41, 32'h0b);
        for (int k = 8; k >= 0; k--) begin
            rd(14'h42);
            chk("tval_cnt", last_rd, TMR ? k : 0);
        end
        rd(14'h05);
        chk("is11_set", {31'b0, last_rd[11]}, {31'b0, TMR});
        chk("int_set", {31'b0, last_int}, {31'b0, TMR});
        rd(14'h42);  chk("tval_reload", last_rd, TMR ? 32'd7 : 32'd0);
        cyc(1'b0, 14'h44, 1'b1, 32'h1, 32'h1, 1'b0, 1'b0);
        rd(14'h05);
        chk("is11_clr", {31'b0, last_rd[11]}, 32'h0);
        chk("int_clr", {31'b0, last_int}, 32'h0);

        wr(14'h41, 32'h09);
        repeat (12) rd(14'h41);
        rd(14'h41);  chk("oneshot_en", last_rd, TMR ? 32'h8 : 32'h0);
        rd(14'h42);  chk("oneshot_tval", last_rd, 32'h0);

        wr(14'h41, 32'h0b);
        repeat (3) rd(14'h42);
        rst = 1'b1;
        rd(14'h42);
        rst = 1'b0;
        rd(14'h42);  chk("rst_tval", last_rd, 32'h0);
        rd(14'h41);  chk("rst_tcfg", last_rd, 32'h0);
        rd(14'h00);  chk("rst_crmd2", last_rd, 32'h8);

        for (int i = 0; i < 600; i++) begin
            logic [13:0] n;
            logic [31:0] v;
            logic [31:0] mk;
            n  = nums[$urandom_range(0, 17)];
            v  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63)
                                             : $urandom;
            mk = ($urandom_range(0, 1) == 0) ? 32'hffff_ffff : $urandom;
            hw_int_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
            ipi_int_in  = ($urandom_range(0, 7) == 0);
            wb_pc       = $urandom;
            wb_ecode    = 6'($urandom);
            wb_esubcode = 9'($urandom);
            cyc($urandom_range(0, 3) != 0, n, $urandom_range(0, 1) == 1,
                mk, v, $urandom_range(0, 15) == 0,
                $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
